// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank strobe generator.
package clk_div_pkg;

  localparam int unsigned DEFAULT_DIV = 20;
  localparam int unsigned MIN_DIV     = 2;

  // Number of high cycles in a period of d cycles.
  function automatic int unsigned ceil_half(input int unsigned d);
    return (d >> 1) + (d & 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle of clk_div_bank; master drives the controls, slave is the bank.
interface clk_div_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
);

  logic [N_CH-1:0]       EN;
  logic [N_CH*CNT_W-1:0] DIV;
  logic [N_CH-1:0]       LOAD;
  logic                  SYNC;
  logic [N_CH-1:0]       CLK_OUT;
  logic [N_CH-1:0]       TICK;
  logic [N_CH-1:0]       LOAD_PEND;

  modport master (
    output EN, DIV, LOAD, SYNC,
    input  CLK_OUT, TICK, LOAD_PEND
  );

  modport slave (
    input  EN, DIV, LOAD, SYNC,
    output CLK_OUT, TICK, LOAD_PEND
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor and registered CLK_OUT/TICK.
// Phase alignment on sync_i exists only when CLK_DIV_SYNC_EN is defined.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int unsigned CntW       = 16,
  parameter int unsigned DefaultDiv = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [CntW-1:0] div_i,
  input  logic            load_i,
  input  logic            sync_i,
  output logic            clk_out_o,
  output logic            tick_o,
  output logic            load_pend_o
);

  localparam logic [CntW-1:0] DefDiv = CntW'(DefaultDiv);

  logic [CntW-1:0] cnt_q, cnt_d, act_div_q, act_div_d, pend_div_q, pend_div_d;
  logic [CntW-1:0] nxt_cnt, half;
  logic            run_q, run_d, pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;
  logic            legal, apply, sync_hit;

`ifdef CLK_DIV_SYNC_EN
  assign sync_hit = sync_i;
`else
  logic unused_sync;
  assign unused_sync = sync_i;
  assign sync_hit    = 1'b0;
`endif

  assign legal   = act_div_q >= CntW'(MIN_DIV);
  assign half    = CntW'(ceil_half(32'(act_div_q)));
  assign nxt_cnt = (cnt_q == act_div_q - 1'b1) ? '0 : cnt_q + 1'b1;

  always_comb begin
    cnt_d      = cnt_q;
    run_d      = run_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    apply      = 1'b0;
    if (!run_q) begin
      cnt_d = '0;
      apply = pend_q;
      if (en_i && legal) begin
        run_d     = 1'b1;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end
    end else if (!en_i || !legal) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (sync_hit) begin
      cnt_d     = '0;
      clk_out_d = 1'b1;
      tick_d    = 1'b1;
      apply     = pend_q;
    end else begin
      cnt_d     = nxt_cnt;
      clk_out_d = nxt_cnt < half;
      tick_d    = nxt_cnt == '0;
      apply     = pend_q && (nxt_cnt == '0);
    end
    if (apply) begin
      act_div_d = pend_div_q;
      pend_d    = 1'b0;
    end
    // A capture on the apply edge stays pending until the next boundary.
    if (load_i) begin
      pend_div_d = div_i;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      run_q      <= 1'b0;
      act_div_q  <= DefDiv;
      pend_div_q <= DefDiv;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign load_pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// N_CH-channel programmable clock-enable/strobe generator.
// Define CLK_DIV_SYNC_EN to make SYNC restart all running channels in phase.
module clk_div_bank #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input logic           CLK,
  input logic           RST_N,
  clk_div_bank_if.slave bus
);

  logic [N_CH-1:0] clk_out, tick, load_pend;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clk_div_chan #(
      .CntW      (CNT_W),
      .DefaultDiv(DEFAULT_DIV)
    ) u_chan (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .en_i       (bus.EN[i]),
      .div_i      (bus.DIV[i*CNT_W +: CNT_W]),
      .load_i     (bus.LOAD[i]),
      .sync_i     (bus.SYNC),
      .clk_out_o  (clk_out[i]),
      .tick_o     (tick[i]),
      .load_pend_o(load_pend[i])
    );
  end

  assign bus.CLK_OUT   = clk_out;
  assign bus.TICK      = tick;
  assign bus.LOAD_PEND = load_pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus queues per-edge expectations, monitor checks them.
module tb_clk_div_bank;

  localparam int unsigned NCh  = 4;
  localparam int unsigned CntW = 16;

  typedef struct {
    int    cyc;
    int    ch;
    logic  co;
    logic  tk;
    logic  pd;
    string nm;
  } exp_t;

  logic CLK;
  logic RST_N;
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  exp_t q[$];

  clk_div_bank_if #(.N_CH(NCh), .CNT_W(CntW)) bus ();

  clk_div_bank #(.N_CH(NCh), .CNT_W(CntW), .DEFAULT_DIV(20)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic exp_at(input int k, input int ch, input logic co, input logic tk,
                        input logic pd, input string nm);
    exp_t e;
    int   idx;
    e.cyc = k; e.ch = ch; e.co = co; e.tk = tk; e.pd = pd; e.nm = nm;
    idx = q.size();
    while (idx > 0 && q[idx-1].cyc > k) idx--;
    q.insert(idx, e);
  endtask

  // Expected square wave of period d, starting at phase ph on edge k.
  task automatic exp_run(input int ch, input int k, input int d, input int ph, input int n,
                         input logic pd, input string nm);
    for (int j = 0; j < n; j++) begin
      int p;
      p = (ph + j) % d;
      exp_at(k + j, ch, p < (d + 1) / 2, p == 0, pd, nm);
    end
  endtask

  task automatic goto(input int k);
    while (edge_n < k) @(negedge CLK);
  endtask

  task automatic set_div(input int ch, input int d);
    bus.DIV[ch*CntW +: CntW] = CntW'(d);
  endtask

  // Monitor: outputs change on clock edges and on async reset assertion.
  initial begin
    exp_t cur;
    forever begin
      @(posedge CLK or negedge RST_N);
      #1;
      while (q.size() > 0 && q[0].cyc <= edge_n) begin
        cur = q.pop_front();
        n_vec++;
        if ({bus.CLK_OUT[cur.ch], bus.TICK[cur.ch], bus.LOAD_PEND[cur.ch]} !==
            {cur.co, cur.tk, cur.pd}) begin
          n_bad++;
          $display("FAIL %s ch%0d edge %0d: clk_out/tick/pend got %b%b%b want %b%b%b",
                   cur.nm, cur.ch, cur.cyc, bus.CLK_OUT[cur.ch], bus.TICK[cur.ch],
                   bus.LOAD_PEND[cur.ch], cur.co, cur.tk, cur.pd);
        end
      end
    end
  end

  initial begin
    int e, k0, k1, r;
    RST_N    = 1'b0;
    bus.EN   = '0;
    bus.DIV  = '0;
    bus.LOAD = '0;
    bus.SYNC = 1'b0;

    goto(2);
    n_vec++;
    if ({bus.CLK_OUT, bus.TICK, bus.LOAD_PEND} !== '0) begin
      n_bad++;
      $display("FAIL in_reset_direct: outputs got %b %b %b want all 0",
               bus.CLK_OUT, bus.TICK, bus.LOAD_PEND);
    end
    for (int c = 0; c < NCh; c++) exp_at(3, c, 1'b0, 1'b0, 1'b0, "reset");
    goto(3);
    RST_N = 1'b1;

    // Default divisor 20 on ch0.
    e = edge_n;
    bus.EN[0] = 1'b1;
    exp_run(0, e + 1, 20, 0, 45, 1'b0, "div20");
    exp_at(e + 1, 1, 1'b0, 1'b0, 1'b0, "idle_ch1");
    goto(e + 45);
    bus.EN[0] = 1'b0;
    exp_at(e + 46, 0, 1'b0, 1'b0, 1'b0, "en_off");

    // Idle loads: ch1=5, ch2=2, ch3=1, then ch3=0.
    e = edge_n;
    set_div(1, 5); set_div(2, 2); set_div(3, 1);
    bus.LOAD = 4'b1110;
    for (int c = 1; c < 4; c++) exp_at(e + 1, c, 1'b0, 1'b0, 1'b1, "idle_pend");
    goto(e + 1);
    bus.LOAD = '0;
    for (int c = 1; c < 4; c++) exp_at(e + 2, c, 1'b0, 1'b0, 1'b0, "idle_apply");
    goto(e + 2);
    bus.EN[3:1] = 3'b111;
    exp_run(1, e + 3, 5, 0, 10, 1'b0, "div5");
    exp_run(2, e + 3, 2, 0, 12, 1'b0, "div2");
    for (int j = 0; j < 6; j++) exp_at(e + 3 + j, 3, 1'b0, 1'b0, 1'b0, "div1");
    goto(e + 8);
    set_div(3, 0);
    bus.LOAD[3] = 1'b1;
    exp_at(e + 9, 3, 1'b0, 1'b0, 1'b1, "div0_pend");
    goto(e + 9);
    bus.LOAD = '0;
    for (int j = 0; j < 6; j++) exp_at(e + 10 + j, 3, 1'b0, 1'b0, 1'b0, "div0");
    goto(e + 15);
    bus.EN[3:1] = 3'b000;
    for (int c = 1; c < 4; c++) exp_at(e + 16, c, 1'b0, 1'b0, 1'b0, "multi_off");

    // Mid-period load, load on wrap edge, EN drop at cnt=7.
    e  = edge_n;
    k0 = e + 1;
    bus.EN[0] = 1'b1;
    exp_run(0, k0, 20, 0, 5, 1'b0, "pre_load");
    goto(k0 + 4);
    set_div(0, 8);
    bus.LOAD[0] = 1'b1;
    exp_run(0, k0 + 5, 20, 5, 15, 1'b1, "pend_20");
    goto(k0 + 5);
    bus.LOAD = '0;
    exp_run(0, k0 + 20, 8, 0, 8, 1'b0, "div8");
    goto(k0 + 27);
    set_div(0, 10);
    bus.LOAD[0] = 1'b1;
    exp_run(0, k0 + 28, 8, 0, 8, 1'b1, "wrap_load");
    goto(k0 + 28);
    bus.LOAD = '0;
    exp_run(0, k0 + 36, 10, 0, 8, 1'b0, "div10");
    goto(k0 + 43);
    bus.EN[0] = 1'b0;
    exp_at(k0 + 44, 0, 1'b0, 1'b0, 1'b0, "en_drop");
    goto(k0 + 44);
    bus.EN[0] = 1'b1;
    k1 = k0 + 45;
    exp_run(0, k1, 10, 0, 4, 1'b0, "restart");

    // Async reset with a pending divisor.
    goto(k1 + 3);
    set_div(0, 6);
    bus.LOAD[0] = 1'b1;
    exp_run(0, k1 + 4, 10, 4, 3, 1'b1, "pend_pre_rst");
    goto(k1 + 4);
    bus.LOAD = '0;
    goto(k1 + 6);
    for (int c = 0; c < NCh; c++) exp_at(k1 + 6, c, 1'b0, 1'b0, 1'b0, "async_rst");
    RST_N = 1'b0;
    exp_at(k1 + 7, 0, 1'b0, 1'b0, 1'b0, "in_rst");
    exp_at(k1 + 8, 0, 1'b0, 1'b0, 1'b0, "in_rst");
    goto(k1 + 8);
    RST_N = 1'b1;
    r = k1 + 8;
    exp_run(0, r + 1, 20, 0, 7, 1'b0, "post_rst");

    // ch1 at D=10 misaligned with ch0, then SYNC pulse.
    goto(r + 1);
    set_div(1, 10);
    bus.LOAD[1] = 1'b1;
    exp_at(r + 2, 1, 1'b0, 1'b0, 1'b1, "ch1_pend");
    goto(r + 2);
    bus.LOAD = '0;
    exp_at(r + 3, 1, 1'b0, 1'b0, 1'b0, "ch1_apply");
    goto(r + 3);
    bus.EN[1] = 1'b1;
    exp_run(1, r + 4, 10, 0, 4, 1'b0, "ch1_free");
    goto(r + 7);
    bus.SYNC = 1'b1;
`ifdef CLK_DIV_SYNC_EN
    exp_run(0, r + 8, 20, 0, 40, 1'b0, "sync_ch0");
    exp_run(1, r + 8, 10, 0, 40, 1'b0, "sync_ch1");
`else
    exp_run(0, r + 8, 20, 7, 40, 1'b0, "nosync_ch0");
    exp_run(1, r + 8, 10, 4, 40, 1'b0, "nosync_ch1");
`endif
    goto(r + 8);
    bus.SYNC = 1'b0;
    goto(r + 50);

    while (q.size() > 0) begin
      exp_t lost;
      lost = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s ch%0d edge %0d: never checked, got none want %b%b%b",
               lost.nm, lost.ch, lost.cyc, lost.co, lost.tk, lost.pd);
    end
    if (n_vec < 12) begin
      n_bad++;
      $display("FAIL too few vectors applied: %0d", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
